// File: rtl/regfile_req_ctrl.sv
// regfile_req_ctrl
//   Request front-end for a synchronous SRAM register file with a CS/WE/RD/Addr
//   port and a 1-cycle registered read. It accepts read and write requests and
//   drives the SRAM control pins from registers. It captures the read data and
//   returns it on a response channel. This block is the only master of the
//   regfile control pins.
//
// Configuration macro: RANGE_CHK_EN
//   When defined, a request with ReqAddr >= DPTH never touches the SRAM.
//   Such a write is dropped. Such a read returns RspData=0 and RspErr=1 after
//   the normal read latency.
//   When undefined, the address is forwarded unchanged and RspErr stays 0.
//
// Handshakes (valid/ready, both channels):
//   A beat transfers on a rising Clk edge where valid and ready are both 1.
//   A source holds valid and its payload stable until that edge. Ready may
//   change freely and has no effect while valid is 0.
//
// Ports
//   Clk, Rst_n          clock, asynchronous active-low reset
//   ReqValid/ReqReady   request handshake (ReqReady = IDLE & Rst_n, combinational)
//   ReqWr/ReqAddr/ReqData  request fields (1 = write; data ignored for reads)
//   RspValid/RspReady   read-response handshake
//   RspData/RspErr      read data, out-of-range flag
//   SramCS/WE/RD/Addr/Din  registered controls to the regfile
//   SramDout            regfile read data, valid the cycle after RD
//   DbgState            current FSM state, for checkers

module regfile_req_ctrl #(
  parameter int ADR  = 8,
  parameter int DAT  = 8,
  parameter int DPTH = 8
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           ReqValid,
  output logic           ReqReady,
  input  logic           ReqWr,
  input  logic [ADR-1:0] ReqAddr,
  input  logic [DAT-1:0] ReqData,
  output logic           RspValid,
  input  logic           RspReady,
  output logic [DAT-1:0] RspData,
  output logic           RspErr,
  output logic           SramCS,
  output logic           SramWE,
  output logic           SramRD,
  output logic [ADR-1:0] SramAddr,
  output logic [DAT-1:0] SramDin,
  input  logic [DAT-1:0] SramDout,
  output logic [2:0]     DbgState
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE_WR = 3'd1;
  localparam logic [2:0] ISSUE_RD = 3'd2;
  localparam logic [2:0] CAPTURE  = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [2:0]     r_state;
  logic           r_cs, r_we, r_rd;
  logic [ADR-1:0] r_addr;
  logic [DAT-1:0] r_din;
  logic           r_rd_err;     // latched at accept, used at capture
  logic           r_rsp_valid;
  logic [DAT-1:0] r_rsp_data;
  logic           r_rsp_err;

  logic w_accept;
  logic w_addr_oor;
  logic w_in_range;

  assign ReqReady   = (r_state == IDLE) & Rst_n;
  assign w_accept   = ReqValid & ReqReady;
  assign w_addr_oor = (32'(ReqAddr) >= DPTH);

`ifdef RANGE_CHK_EN
  assign w_in_range = ~w_addr_oor;
`else
  logic w_unused_oor;
  assign w_in_range   = 1'b1;
  assign w_unused_oor = w_addr_oor;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_rd_err    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // An out-of-range request still walks the FSM, so the latency
            // stays fixed, but it never asserts CS.
            r_cs     <= w_in_range;
            r_we     <= ReqWr & w_in_range;
            r_rd     <= ~ReqWr & w_in_range;
            r_addr   <= ReqAddr;
            r_din    <= ReqWr ? ReqData : '0;
            r_rd_err <= ~w_in_range;
            r_state  <= ReqWr ? ISSUE_WR : ISSUE_RD;
          end
        end
        ISSUE_WR: begin
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_rd    <= 1'b0;
          r_state <= IDLE;
        end
        ISSUE_RD: begin
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_rd    <= 1'b0;
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          // SramDout is valid in this cycle (registered read issued last cycle).
          r_rsp_data  <= r_rd_err ? '0 : SramDout;
          r_rsp_err   <= r_rd_err;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (RspReady) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_rd    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign SramCS   = r_cs;
  assign SramWE   = r_we;
  assign SramRD   = r_rd;
  assign SramAddr = r_addr;
  assign SramDin  = r_din;
  assign RspValid = r_rsp_valid;
  assign RspData  = r_rsp_data;
  assign RspErr   = r_rsp_err;
  assign DbgState = r_state;

endmodule

// File: tb/tb_regfile_req_ctrl.sv
// tb_regfile_req_ctrl
//   Self-checking bench for regfile_req_ctrl, with a behavioural regfile
//   attached to the SRAM pins. Expected read responses are pushed at request
//   accept from an array model of memory. A monitor pops and compares on each
//   response handshake.
//   Build with +define+RANGE_CHK_EN to exercise the range-check feature.

module tb_regfile_req_ctrl;

  localparam int ADR  = 8;
  localparam int DAT  = 8;
  localparam int DPTH = 8;
  localparam int AW   = $clog2(DPTH);
  localparam int W    = DAT + 1;   // {err, data}

  // ---------------- clock / reset ----------------
  logic Clk;
  logic Rst_n;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic           ReqValid, ReqReady, ReqWr;
  logic [ADR-1:0] ReqAddr;
  logic [DAT-1:0] ReqData;
  logic           RspValid, RspReady, RspErr;
  logic [DAT-1:0] RspData;
  logic           SramCS, SramWE, SramRD;
  logic [ADR-1:0] SramAddr;
  logic [DAT-1:0] SramDin, SramDout;
  logic [2:0]     unused_dbg_state;

  logic rr_rand = 1'b0;
  logic rr_dir  = 1'b1;
  logic rr_bit  = 1'b1;
  assign RspReady = rr_rand ? rr_bit : rr_dir;

  regfile_req_ctrl #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWr(ReqWr),
    .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
    .SramCS(SramCS), .SramWE(SramWE), .SramRD(SramRD),
    .SramAddr(SramAddr), .SramDin(SramDin), .SramDout(SramDout),
    .DbgState(unused_dbg_state)
  );

  // ---------------- regfile model (1-cycle registered read) ----------------
  logic [DAT-1:0] sram [DPTH];
  always @(posedge Clk) begin
    if (SramCS && SramWE && (32'(SramAddr) < DPTH)) sram[SramAddr[AW-1:0]] <= SramDin;
    if (SramCS && SramRD)
      SramDout <= (32'(SramAddr) < DPTH) ? sram[SramAddr[AW-1:0]] : '0;
  end

  // random response-ready source
  initial begin
    forever begin
      @(posedge Clk); #1;
      rr_bit = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int viol   = 0;
  logic [W-1:0]   exp_q[$];
  logic [DAT-1:0] ref_mem [DPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // High-level model: update memory on a write, predict the response of a read.
  task automatic model_accept(input logic wr, input logic [ADR-1:0] a, input logic [DAT-1:0] d);
    bit oor;
`ifdef RANGE_CHK_EN
    oor = (32'(a) >= DPTH);
`else
    oor = 1'b0;
`endif
    if (wr) begin
      if (!oor) ref_mem[a[AW-1:0]] = d;
    end else begin
      if (oor) exp_q.push_back({1'b1, {DAT{1'b0}}});
      else     exp_q.push_back({1'b0, ref_mem[a[AW-1:0]]});
    end
  endtask

  // monitor
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (SramWE && SramRD) viol++;
      if (RspValid && RspReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got response 0x%0h, required none", RspData);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("rsp_data", 32'(RspData), 32'(e[DAT-1:0]));
          chk("rsp_err",  32'(RspErr),  32'(e[DAT]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called and returns at #1 after a posedge; returns in cycle T+1 of the accept.
  task automatic issue(input logic wr, input logic [ADR-1:0] a, input logic [DAT-1:0] d,
                       input bit keep, output int acc);
    int n;
    n   = 0;
    acc = 0;
    ReqWr = wr; ReqAddr = a; ReqData = d; ReqValid = 1'b1;
    while (!ReqReady && n < 200) begin @(posedge Clk); #1; n++; end
    if (!ReqReady) begin
      checks++;
      errors++;
      $display("FAIL req_accept: ReqReady=0, required 1 within 200 cycles");
      ReqValid = 1'b0;
      return;
    end
    model_accept(wr, a, d);
    @(posedge Clk); #1;
    acc = cyc;
    if (!keep) ReqValid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ReqReady"}, 32'(ReqReady), 0);
    chk({tag, "_RspValid"}, 32'(RspValid), 0);
    chk({tag, "_RspErr"},   32'(RspErr),   0);
    chk({tag, "_RspData"},  32'(RspData),  0);
    chk({tag, "_SramCS"},   32'(SramCS),   0);
    chk({tag, "_SramWE"},   32'(SramWE),   0);
    chk({tag, "_SramRD"},   32'(SramRD),   0);
    chk({tag, "_SramAddr"}, 32'(SramAddr), 0);
    chk({tag, "_SramDin"},  32'(SramDin),  0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t, prev, n;
    bit seen;
    logic [DAT-1:0] held;
    logic [DAT-1:0] wdat [DPTH];

    Rst_n = 1'b0; ReqValid = 1'b0; ReqWr = 1'b0; ReqAddr = '0; ReqData = '0;
    rr_rand = 1'b0; rr_dir = 1'b1;
    for (int i = 0; i < DPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge Clk); #1;
    check_all_zero("reset");
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("ready_after_reset", 32'(ReqReady), 1);

    // 1. reset in the middle of a read
    issue(1'b0, 8'd3, 8'h00, 1'b0, t);
    chk("midrd_cs", 32'(SramCS), 1);
    chk("midrd_rd", 32'(SramRD), 1);
    void'(exp_q.pop_back());           // this read is discarded by the reset
    Rst_n = 1'b0; #1;
    check_all_zero("midrd_reset");
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("midrd_ready", 32'(ReqReady), 1);
    seen = 1'b0;
    repeat (6) begin @(posedge Clk); #1; if (RspValid) seen = 1'b1; end
    chk("midrd_no_rsp", 32'(seen), 0);

    // 2. write 0xA5 to addr 3, read it back
    issue(1'b1, 8'd3, 8'hA5, 1'b0, t);
    chk("wr_cs", 32'(SramCS), 1);
    chk("wr_we", 32'(SramWE), 1);
    chk("wr_rd", 32'(SramRD), 0);
    chk("wr_addr", 32'(SramAddr), 3);
    chk("wr_din", 32'(SramDin), 32'h A5);
    @(posedge Clk); #1;
    chk("wr_cs_off", 32'(SramCS), 0);
    chk("wr_we_off", 32'(SramWE), 0);
    issue(1'b0, 8'd3, 8'h77, 1'b0, t);
    chk("rd_din_zero", 32'(SramDin), 0);
    chk("rd_valid_t1", 32'(RspValid), 0);
    @(posedge Clk); #1;
    chk("rd_valid_t2", 32'(RspValid), 0);
    @(posedge Clk); #1;
    chk("rd_valid_t3", 32'(RspValid), 1);
    chk("rd_data_t3", 32'(RspData), 32'h A5);
    @(posedge Clk); #1;
    chk("rd_valid_drop", 32'(RspValid), 0);

    // 3. backpressure
    rr_dir = 1'b0;
    issue(1'b0, 8'd3, 8'h00, 1'b0, t);
    n = 0;
    while (!RspValid && n < 10) begin @(posedge Clk); #1; n++; end
    chk("bp_valid", 32'(RspValid), 1);
    held = RspData;
    chk("bp_data", 32'(held), 32'h A5);
    ReqValid = 1'b1; ReqWr = 1'b1; ReqAddr = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("bp_hold_valid", 32'(RspValid), 1);
      chk("bp_hold_data", 32'(RspData), 32'(held));
      chk("bp_ready_low", 32'(ReqReady), 0);
    end
    ReqValid = 1'b0;
    rr_dir = 1'b1;
    @(posedge Clk); #1;
    chk("bp_release", 32'(RspValid), 0);

    // 4. back-to-back writes with ReqValid held, then reads
    prev = 0;
    for (int i = 0; i < DPTH; i++) begin
      wdat[i] = 8'($urandom);
      issue(1'b1, 8'(i), wdat[i], 1'b1, t);
      if (i > 0) chk("b2b_gap", 32'(t - prev), 2);
      prev = t;
    end
    ReqValid = 1'b0;
    for (int i = 0; i < DPTH; i++) issue(1'b0, 8'(i), 8'h00, 1'b0, t);

`ifdef RANGE_CHK_EN
    // 5. range check
    issue(1'b0, 8'd8, 8'h00, 1'b0, t);
    chk("oor_rd_cs", 32'(SramCS), 0);
    issue(1'b1, 8'd200, 8'h5A, 1'b0, t);
    chk("oor_wr_cs", 32'(SramCS), 0);
    issue(1'b1, 8'd0, 8'h11, 1'b0, t);
    issue(1'b1, 8'd8, 8'h22, 1'b0, t);
    issue(1'b0, 8'd0, 8'h00, 1'b0, t);
    issue(1'b0, 8'd200, 8'h00, 1'b0, t);
`endif

    // 6. random traffic
    rr_rand = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      logic [ADR-1:0] a;
      ReqValid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
`ifdef RANGE_CHK_EN
      a = ($urandom_range(0, 9) == 0) ? 8'd200 : 8'($urandom_range(0, 11));
`else
      a = 8'($urandom_range(0, DPTH - 1));
`endif
      issue(1'($urandom_range(0, 1)), a, 8'($urandom), 1'b0, t);
    end
    rr_rand = 1'b0;
    rr_dir  = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge Clk); #1; n++; end
    repeat (3) @(posedge Clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("we_rd_overlap", 32'(viol), 0);
    chk("final_no_valid", 32'(RspValid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
